// File: rtl/ahb_cmd_master.sv
// AHB-lite single-master initiator: buffered commands issued as pipelined NONSEQ singles.
// Latency: push at edge N -> NONSEQ after N+1 -> data phase closes next hready edge -> rsp the cycle after.
module ahb_cmd_master #(
    parameter int addrWidth = 8,
    parameter int dataWidth = 32,
    parameter int cmdDepth  = 4
) (
    input  logic                 hresetn,
    input  logic                 hclk,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic                 rsp_write,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 hselx,
    output logic [addrWidth-1:0] haddr,
    output logic                 hwrite,
    output logic [1:0]           htrans,
    output logic [dataWidth-1:0] hwdata,
    input  logic                 hready,
    input  logic [dataWidth-1:0] hrdata,
    output logic                 busy
);

    localparam int PW = $clog2(cmdDepth);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(cmdDepth);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] DP_IDLE = 2'd0;
    localparam logic [1:0] DP_RD   = 2'd1;
    localparam logic [1:0] DP_WR   = 2'd2;

    logic                 fifo_write [cmdDepth];
    logic [addrWidth-1:0] fifo_addr  [cmdDepth];
    logic [dataWidth-1:0] fifo_wdata [cmdDepth];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [PW:0]          fifo_count;
    logic                 fifo_empty, push, pop;

    logic [dataWidth-1:0] ap_wdata;
    logic [1:0]           dp_state;

    assign fifo_empty = (fifo_count == '0);
    // No pass-through when full: a same-cycle pop does not open cmd_ready.
    assign cmd_ready  = (fifo_count != CNT_FULL);
    assign push       = cmd_valid & cmd_ready;
    assign pop        = hready & ~fifo_empty;

    always_ff @(posedge hclk) begin
        if (push) begin
            fifo_write[wr_ptr] <= cmd_write;
            fifo_addr[wr_ptr]  <= cmd_addr;
            fifo_wdata[wr_ptr] <= cmd_wdata;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Address phase: only advances on hready so the bus stays stable during wait states.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            htrans   <= HTRANS_IDLE;
            haddr    <= '0;
            hwrite   <= 1'b0;
            ap_wdata <= '0;
        end else if (hready) begin
            if (!fifo_empty) begin
                htrans   <= HTRANS_NONSEQ;
                haddr    <= fifo_addr[rd_ptr];
                hwrite   <= fifo_write[rd_ptr];
                ap_wdata <= fifo_wdata[rd_ptr];
            end else begin
                htrans   <= HTRANS_IDLE;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_state <= DP_IDLE;
            hwdata   <= '0;
        end else if (hready) begin
            if (htrans == HTRANS_NONSEQ) begin
                dp_state <= hwrite ? DP_WR : DP_RD;
                if (hwrite) hwdata <= ap_wdata;
            end else begin
                dp_state <= DP_IDLE;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= hready && (dp_state != DP_IDLE);
            if (hready && (dp_state != DP_IDLE)) begin
                rsp_write <= (dp_state == DP_WR);
                rsp_rdata <= (dp_state == DP_RD) ? hrdata : '0;
            end
        end
    end

    assign hselx = (htrans == HTRANS_NONSEQ);
    assign busy  = !fifo_empty || (htrans == HTRANS_NONSEQ) || (dp_state != DP_IDLE);

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: behavioural AHB slave memory plus an in-order response scoreboard.
module tb_ahb_cmd_master;

    logic        hresetn, hclk;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_write;
    logic [31:0] rsp_rdata;
    logic        hselx, hwrite, hready, busy;
    logic [7:0]  haddr;
    logic [1:0]  htrans;
    logic [31:0] hwdata, hrdata;

    ahb_cmd_master #(.addrWidth(8), .dataWidth(32), .cmdDepth(4)) dut (
        .hresetn(hresetn), .hclk(hclk),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .hselx(hselx), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
        .hwdata(hwdata), .hready(hready), .hrdata(hrdata), .busy(busy)
    );

    typedef struct {
        logic        w;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [256];
    logic [31:0] slv_mem   [256];
    logic        sl_vld, sl_wr;
    logic [7:0]  sl_addr;
    int          n_tests = 0, n_fail = 0, rsp_seen = 0;
    int          cur_run = 0, max_run = 0;

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    // Slave model: data phase tracked on hready edges, read data served combinationally.
    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            sl_vld <= 1'b0;
            sl_wr  <= 1'b0;
            sl_addr <= 8'h0;
        end else if (hready) begin
            if (sl_vld && sl_wr) slv_mem[sl_addr] <= hwdata;
            sl_vld  <= (htrans == 2'b10);
            sl_wr   <= hwrite;
            sl_addr <= haddr;
        end
    end
    assign hrdata = slv_mem[sl_addr];

    always @(negedge hclk) begin
        if (hresetn && rsp_valid) begin
            exp_t e;
            rsp_seen++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got write=%0b rdata=%h, required no response", rsp_write, rsp_rdata);
            end else begin
                e = sb.pop_front();
                if (rsp_write !== e.w || rsp_rdata !== e.d) begin
                    n_fail++;
                    $display("FAIL rsp_order: got write=%0b rdata=%h, required write=%0b rdata=%h",
                             rsp_write, rsp_rdata, e.w, e.d);
                end
            end
        end
        if (htrans == 2'b10) cur_run++;
        else cur_run = 0;
        if (cur_run > max_run) max_run = cur_run;
    end

    task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d);
        int   n;
        exp_t e;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(posedge hclk); #1; n++;
        end
        if (n >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: cmd_ready stayed %b, required 1 within 200 cycles", cmd_ready);
        end else begin
            @(posedge hclk);
            e.w = w;
            e.d = w ? 32'h0 : model_mem[a];
            if (w) model_mem[a] = d;
            sb.push_back(e);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy !== 1'b0 || sb.size() != 0 || rsp_valid !== 1'b0) && n < 500) begin
            @(posedge hclk); #1; n++;
        end
        n_tests++;
        if (n >= 500) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: busy=%b pending=%0d, required idle within 500 cycles", nm, busy, sb.size());
        end
    endtask

    task automatic test_reset();
        int seen0;
        n_tests++;
        if (htrans !== 2'b00 || hselx !== 1'b0 || haddr !== 8'h0 || hwrite !== 1'b0 || hwdata !== 32'h0 ||
            rsp_valid !== 1'b0 || rsp_write !== 1'b0 || rsp_rdata !== 32'h0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: htrans=%b hselx=%b haddr=%h rsp_valid=%b busy=%b cmd_ready=%b, required 0/0/0/0/0/1",
                     htrans, hselx, haddr, rsp_valid, busy, cmd_ready);
        end
        @(posedge hclk); #1; hresetn = 1'b1;
        send(1'b1, 8'hF0, 32'h1); send(1'b1, 8'hF1, 32'h2); send(1'b1, 8'hF2, 32'h3);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_busy_before: got %b, required 1", busy);
        end
        seen0 = rsp_seen;
        hresetn = 1'b0;
        #1;
        n_tests++;
        if (htrans !== 2'b00 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midstream: htrans=%b rsp_valid=%b cmd_ready=%b busy=%b, required 00/0/1/0",
                     htrans, rsp_valid, cmd_ready, busy);
        end
        sb.delete();
        repeat (2) @(posedge hclk);
        #1; hresetn = 1'b1;
        repeat (10) @(posedge hclk);
        #1;
        n_tests++;
        if (rsp_seen != seen0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dropped: got %0d responses busy=%b, required 0 responses busy=0", rsp_seen - seen0, busy);
        end
    endtask

    task automatic test_write_read();
        int seen0 = rsp_seen;
        send(1'b1, 8'h10, 32'hDEADBEEF);
        n_tests++;
        if (htrans !== 2'b00) begin
            n_fail++; $display("FAIL wr_no_bypass: htrans=%b, required 00 right after push", htrans);
        end
        send(1'b0, 8'h10, 32'h0);
        n_tests++;
        if (htrans !== 2'b10 || hselx !== 1'b1 || haddr !== 8'h10 || hwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_addr_phase: htrans=%b hselx=%b haddr=%h hwrite=%b, required 10/1/10/1", htrans, hselx, haddr, hwrite);
        end
        wait_idle("write_read");
        n_tests++;
        if (rsp_seen - seen0 != 2) begin
            n_fail++; $display("FAIL wr_rsp_count: got %0d, required 2", rsp_seen - seen0);
        end
    endtask

    task automatic test_back_to_back();
        max_run = 0; cur_run = 0;
        for (int i = 0; i < 4; i++) send(1'b1, 8'(i), 32'h100 + 32'(i));
        for (int i = 0; i < 4; i++) send(1'b0, 8'(i), 32'h0);
        wait_idle("back_to_back");
        n_tests++;
        if (max_run != 8) begin
            n_fail++; $display("FAIL b2b_nonseq_run: got %0d consecutive NONSEQ cycles, required 8", max_run);
        end
    endtask

    task automatic test_wait_states();
        int seen0;
        send(1'b1, 8'h20, 32'hCAFE0020);
        wait_idle("wait_pre");
        seen0 = rsp_seen;
        send(1'b1, 8'h24, 32'h5555AAAA);
        send(1'b0, 8'h20, 32'h0);
        @(posedge hclk); #1;
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge hclk); #1;
            n_tests++;
            if (htrans !== 2'b10 || haddr !== 8'h20 || hwrite !== 1'b0 || hwdata !== 32'h5555AAAA || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_stable: htrans=%b haddr=%h hwdata=%h rsp_valid=%b, required 10/20/5555aaaa/0",
                         htrans, haddr, hwdata, rsp_valid);
            end
        end
        hready = 1'b1;
        wait_idle("wait_states");
        n_tests++;
        if (rsp_seen - seen0 != 2) begin
            n_fail++; $display("FAIL wait_rsp_count: got %0d, required 2", rsp_seen - seen0);
        end
    endtask

    task automatic test_fifo_full();
        int seen0 = rsp_seen;
        hready = 1'b0;
        send(1'b1, 8'h30, 32'hA0A0A0A0);
        send(1'b1, 8'h31, 32'hB1B1B1B1);
        send(1'b0, 8'h30, 32'h0);
        send(1'b0, 8'h31, 32'h0);
        n_tests++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1 || htrans !== 2'b00) begin
            n_fail++;
            $display("FAIL full_ready: cmd_ready=%b busy=%b htrans=%b, required 0/1/00", cmd_ready, busy, htrans);
        end
        fork
            send(1'b1, 8'h32, 32'hC2C2C2C2);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(posedge hclk); #1;
                    n_tests++;
                    if (cmd_ready !== 1'b0) begin
                        n_fail++; $display("FAIL full_hold: cmd_ready=%b, required 0 while stalled", cmd_ready);
                    end
                end
                hready = 1'b1;
            end
        join
        wait_idle("fifo_full");
        n_tests++;
        if (rsp_seen - seen0 != 5) begin
            n_fail++; $display("FAIL full_rsp_count: got %0d, required 5", rsp_seen - seen0);
        end
    endtask

    task automatic test_wrap();
        int seen0 = rsp_seen;
        for (int i = 0; i < 10; i++) begin
            send(1'b1, 8'h40 + 8'(i), 32'h10000000 + 32'(i * 7));
            send(1'b0, 8'h40 + 8'(i), 32'h0);
        end
        wait_idle("wrap");
        n_tests++;
        if (busy !== 1'b0 || rsp_seen - seen0 != 20) begin
            n_fail++; $display("FAIL wrap_end: busy=%b responses=%0d, required 0/20", busy, rsp_seen - seen0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 32'h0;
            slv_mem[i]   = 32'h0;
        end
        hresetn = 1'b0; hready = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h0; cmd_wdata = 32'h0;
        repeat (2) @(posedge hclk);
        #1;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_wait_states();
        test_fifo_full();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
